// File: rtl/saes_pkg.sv
// Shared S-AES definitions: nibble S-boxes, round constants, GF(2^4) multiply,
// row/column helpers and the decrypt-core state encoding.
package saes_pkg;

  localparam logic [3:0] SBOX [16] = '{
    4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
    4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7
  };

  localparam logic [3:0] INV_SBOX [16] = '{
    4'hA, 4'h5, 4'h9, 4'hB, 4'h1, 4'h7, 4'h8, 4'hF,
    4'h6, 4'h0, 4'h2, 4'h3, 4'hC, 4'h4, 4'hD, 4'hE
  };

  localparam logic [7:0] RCON1 = 8'h80;
  localparam logic [7:0] RCON2 = 8'h30;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEYX,
    S_RND1,
    S_RND2,
    S_OUT
  } state_e;

  // Shift-and-add multiply, reducing by x^4+x+1 each time the operand overflows.
  function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction

  // SubNib(RotNib(w)) ^ rcon, the non-linear term of the key schedule.
  function automatic logic [7:0] key_g(input logic [7:0] w, input logic [7:0] rcon);
    return rcon ^ {SBOX[w[3:0]], SBOX[w[7:4]]};
  endfunction

  function automatic logic [15:0] inv_shift_rows(input logic [15:0] s);
    return {s[15:12], s[3:0], s[7:4], s[11:8]};
  endfunction

  function automatic logic [15:0] inv_mix_col(input logic [15:0] s);
    return {gf16_mul(4'h9, s[15:12]) ^ gf16_mul(4'h2, s[11:8]),
            gf16_mul(4'h2, s[15:12]) ^ gf16_mul(4'h9, s[11:8]),
            gf16_mul(4'h9, s[7:4])   ^ gf16_mul(4'h2, s[3:0]),
            gf16_mul(4'h2, s[7:4])   ^ gf16_mul(4'h9, s[3:0])};
  endfunction

endpackage

// File: rtl/saes_inv_sbox.sv
// Combinational 4-bit S-AES inverse S-box, mirror of the encrypt-side S-box.
module saes_inv_sbox
  import saes_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  assign nib_o = INV_SBOX[nib_i];

endmodule

// File: rtl/saes_decrypt_core.sv
// Iterative S-AES decryption core: key expansion (skippable on key reuse),
// two inverse rounds, valid/ready handshakes on both sides.
module saes_decrypt_core
  import saes_pkg::*;
#(
  parameter bit KEY_REUSE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] ciphertext,
  input  logic [15:0] key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] plaintext,
  output logic        busy
);

  state_e state_q, state_d;

  logic [15:0] ct_q, key_q;
  logic [15:0] k0_q, k1_q, k2_q;
  logic [15:0] d_q, pt_q;
  logic        cache_valid_q, out_valid_q;
  logic        key_hit;
  logic [7:0]  w2, w3, w4, w5;
  logic [15:0] isub_in, isub_out;

  // K0 is the raw key of the last expansion, so it doubles as the cache tag.
  assign key_hit = KEY_REUSE && cache_valid_q && (key == k0_q);

  always_comb begin
    w2 = key_q[15:8] ^ key_g(key_q[7:0], RCON1);
    w3 = w2 ^ key_q[7:0];
    w4 = w2 ^ key_g(w3, RCON2);
    w5 = w4 ^ w3;
  end

  // One bank of four inverse S-boxes serves both rounds.
  assign isub_in = inv_shift_rows((state_q == S_RND1) ? (ct_q ^ k2_q) : d_q);

  for (genvar g = 0; g < 4; g++) begin : g_isbox
    saes_inv_sbox u_isbox (
      .nib_i (isub_in[4*g +: 4]),
      .nib_o (isub_out[4*g +: 4])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = key_hit ? S_RND1 : S_KEYX;
      S_KEYX:  state_d = S_RND1;
      S_RND1:  state_d = S_RND2;
      S_RND2:  state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ct_q          <= '0;
      key_q         <= '0;
      k0_q          <= '0;
      k1_q          <= '0;
      k2_q          <= '0;
      d_q           <= '0;
      pt_q          <= '0;
      out_valid_q   <= 1'b0;
      cache_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          ct_q  <= ciphertext;
          key_q <= key;
        end
        S_KEYX: begin
          k0_q          <= key_q;
          k1_q          <= {w2, w3};
          k2_q          <= {w4, w5};
          cache_valid_q <= 1'b1;
        end
        S_RND1: d_q <= inv_mix_col(isub_out ^ k1_q);
        S_RND2: begin
          pt_q        <= isub_out ^ k0_q;
          out_valid_q <= 1'b1;
        end
        S_OUT: if (out_ready) out_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign plaintext = pt_q;

endmodule

// File: doc/saes_decrypt_core.md
Name: saes_decrypt_core

Overview:
- Iterative Simplified-AES (16-bit block, 16-bit key, 2-round) decryption engine. It is the receive-side counterpart of the S-AES encryption datapath.
- Accepts ciphertext and key over a valid/ready handshake, expands the round keys, and runs two inverse rounds.
- Presents plaintext over a valid/ready handshake.
- Sits between the link/packet layer and the consumer of decrypted nibble data.

Parameters:
- KEY_REUSE, 1: when 1, the key-expansion cycle is skipped if the accepted key equals the last expanded key. When 0, key expansion runs every block.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  ciphertext/key offered
- in_ready  out  1  core can accept a block
- ciphertext  in  16  block to decrypt, nibbles [15:12]..[3:0] = n0..n3
- key  in  16  cipher key
- out_valid  out  1  plaintext available
- out_ready  in  1  consumer accepts plaintext
- plaintext  out  16  decrypted block
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, plaintext=16'h0000, busy=0, key_cache_valid=0. Round-key registers are cleared to 0.
- States: IDLE, KEYX, RND1, RND2, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register ciphertext and key.
  - Go to KEYX. If KEY_REUSE=1, key_cache_valid=1 and key==cached key, go straight to RND1.
- KEYX (1 cycle):
  - w0=key[15:8], w1=key[7:0].
  - w2 = w0 ^ 8'h80 ^ SubNib(RotNib(w1)); w3 = w2 ^ w1.
  - w4 = w2 ^ 8'h30 ^ SubNib(RotNib(w3)); w5 = w4 ^ w3.
  - Register K0={w0,w1}, K1={w2,w3}, K2={w4,w5}. Set key_cache_valid=1.
  - SubNib uses the forward S-box; RotNib swaps the nibbles.
  - Go to RND1.
- RND1 (1 cycle):
  - d = InvMixCol(InvSubNib(InvShiftRows(ct ^ K2)) ^ K1), registered.
  - Go to RND2.
- RND2 (1 cycle):
  - plaintext <= InvSubNib(InvShiftRows(d)) ^ K0.
  - out_valid <= 1. Go to OUT.
- OUT:
  - plaintext and out_valid are held stable until out_valid&&out_ready.
  - On that handshake: out_valid <= 0 and go to IDLE. in_ready rises the following cycle.
  - No accept-and-emit overlap.
- InvShiftRows swaps nibbles n1 and n3.
- InvSubNib maps 0..F -> A,5,9,B,1,7,8,F,6,0,2,3,C,4,D,E.
- InvMixCol operates per column (n0,n1) and (n2,n3) with matrix [[9,2],[2,9]] over GF(2^4), modulus x^4+x+1.
- Latency: accept edge T -> out_valid high after edge T+3 (KEYX taken) or T+2 (key reused).
- in_ready=0 in every state other than IDLE. in_valid outside IDLE is ignored and no data is captured.
- Data changes: ciphertext/key changes while not accepted have no effect. plaintext changes only on the RND2 edge.
- rst asserted in any state overrides everything:
  - Next cycle state=IDLE, out_valid=0, key_cache_valid=0.
  - A partially processed block is discarded. No output is produced for it.
- KEY_REUSE=0: KEYX is always taken and key_cache_valid is ignored.

Decomposition:
- Package saes_pkg:
  - forward and inverse S-box nibble tables
  - RCON1=8'h80, RCON2=8'h30
  - gf16_mul function (x^4+x+1)
  - state enum for saes_decrypt_core
- Sub-module saes_inv_sbox: combinational 4-bit inverse S-box, instantiated four times. It is the mirror of the existing encrypt S-box.
- The forward S-box is reused for key expansion.

Test Plan:
- Known vector: key=16'h4AF5, ciphertext=16'h24EC, out_ready=1 -> plaintext=16'hD728, out_valid high exactly 3 cycles after accept, in_ready low during those cycles.
- Key reuse: second block with the same key 16'h4AF5, ciphertext 16'h24EC -> same plaintext 16'hD728 after 2 cycles. With KEY_REUSE=0 the latency is 3 cycles.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> plaintext stable at 16'hD728, in_ready=0, then one handshake returns the core to IDLE.
- Busy-ignore: in_valid pulsed with ciphertext=16'hFFFF during RND1 -> no capture, output is still 16'hD728.
- Mid-operation reset: rst asserted in RND1 -> out_valid stays 0. The next block with key 16'h4AF5 takes the 3-cycle path, because the cache is cleared.
- Inverse S-box exhaustive check on saes_inv_sbox: feeding the encrypt S-box output for inputs 0..F returns the original input for all 16 values.
